// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a synchronized lock, requires the lock
// to stay stable before releasing the core reset, and retries on a lock timeout or a lock loss.
module pll_reset_ctrl #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    S_PLL_RST     = 2'd0,
    S_WAIT_LOCK   = 2'd1,
    S_LOCK_STABLE = 2'd2,
    S_RUN         = 2'd3
  } state_e;

  localparam logic [16:0] RST_LAST     = 17'(RST_CYCLES - 1);
  localparam logic [16:0] LOCK_LAST    = 17'(LOCK_CYCLES - 1);
  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic        lost_q, lost_d;
  logic        sync1_q, sync2_q;
  logic        retry_inc;
  logic        locked_s;
  logic        pll_rst_q, sys_reset_q, ready_q;

  assign locked_s = sync2_q;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 17'd1;
    lost_d    = lost_q;
    retry_inc = 1'b0;

    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock is tested first so a lock arriving on the timeout cycle is never discarded.
        if (locked_s) begin
          state_d = S_LOCK_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_PLL_RST;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
      end
      S_LOCK_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d   = S_PLL_RST;
          lost_d    = 1'b1;
          retry_inc = 1'b1;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    retry_d = (retry_inc && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      sync1_q     <= locked_in;
      sync2_q     <= sync1_q;
      // Output flops track the next state, so they always equal a decode of state_q.
      pll_rst_q   <= (state_d == S_PLL_RST);
      sys_reset_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lost_q;

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL provide parameter RST_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset attempt; legal range 1..65536.
REQ-002 SHALL provide parameter LOCK_CYCLES, default 1024: number of consecutive synchronized-lock cycles required before release; legal range 1..65536.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 65536: maximum cycles to wait for lock before retrying; legal range 1..65536.
REQ-004 SHALL have port refclk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port locked_in, input, 1 bit: PLL locked indication, asynchronous to refclk.
REQ-007 SHALL have port pll_rst, output, 1 bit: reset to the PLL, active-high.
REQ-008 SHALL have port sys_reset, output, 1 bit: core reset, active-high, low only while locked and stable.
REQ-009 SHALL have port ready, output, 1 bit: high exactly when sys_reset is low.
REQ-010 SHALL have port retry_cnt, output, 8 bits: number of PLL reset attempts caused by timeout or lock loss, saturating.
REQ-011 SHALL have port lock_lost, output, 1 bit: sticky flag, set when lock drops in RUN.

Function
REQ-012 SHALL synchronize locked_in through two refclk flops into locked_s; only locked_s drives decisions (2-cycle latency).
REQ-013 SHALL implement four states: PLL_RST, WAIT_LOCK, LOCK_STABLE, RUN, with one shared cycle counter at least 17 bits wide.
REQ-014 SHALL decode outputs from the state register only: pll_rst = (state==PLL_RST); sys_reset = (state!=RUN); ready = (state==RUN).
REQ-015 PLL_RST: counter increments each cycle; when counter==RST_CYCLES-1, go to WAIT_LOCK and clear counter.
REQ-016 WAIT_LOCK: if locked_s, go to LOCK_STABLE and clear counter; else if counter==TIMEOUT_CYCLES-1, go to PLL_RST, clear counter, increment retry_cnt; else increment counter.
REQ-017 LOCK_STABLE: if !locked_s, go to WAIT_LOCK and clear counter; else if counter==LOCK_CYCLES-1, go to RUN; else increment counter.
REQ-018 RUN: if !locked_s, go to PLL_RST, clear counter, set lock_lost, increment retry_cnt; otherwise remain in RUN.
REQ-019 retry_cnt SHALL saturate at 255 and never wrap.
REQ-020 lock_lost SHALL stay set until rst; WAIT_LOCK timeouts SHALL NOT set it.
REQ-021 The lock check SHALL take priority over the timeout when locked_s rises on the same cycle the timeout count is reached in WAIT_LOCK.

Reset
REQ-022 While rst is sampled high: state=PLL_RST, counter=0, both sync flops=0, retry_cnt=0, lock_lost=0; hence pll_rst=1, sys_reset=1, ready=0.
REQ-023 rst asserted in any state, including mid-count or RUN, SHALL take effect at the next edge and restart the full sequence.
REQ-024 With locked_in high throughout, ready SHALL rise exactly RST_CYCLES+1+LOCK_CYCLES edges after the first edge with rst low.

Verification (RST_CYCLES=4, LOCK_CYCLES=8, TIMEOUT_CYCLES=32)
REQ-025 Release rst with locked_in=1 -> pll_rst high for edges 1-4, ready=1 and sys_reset=0 from edge 13, retry_cnt=0.
REQ-026 locked_in held 0 -> pll_rst pulses 4 cycles every 36 cycles, retry_cnt increments per pulse and holds at 255 after 255 retries, ready stays 0, lock_lost=0.
REQ-027 locked_in=1, then a 1-cycle low pulse after 5 LOCK_STABLE cycles -> return to WAIT_LOCK; ready rises 8 stable cycles after the glitch clears (not earlier); retry_cnt=0.
REQ-028 In RUN, drop locked_in -> ready falls and pll_rst rises within 3 edges of the drop; lock_lost=1, retry_cnt=1. Re-raise locked_in -> ready returns after 4+1+8 edges plus sync latency.
REQ-029 Assert rst for 1 cycle while in RUN with lock_lost=1 and retry_cnt=3 -> next edge: ready=0, pll_rst=1, lock_lost=0, retry_cnt=0.
REQ-030 TIMEOUT_CYCLES=1, locked_in low -> retry_cnt increments every 5 cycles, and no WAIT_LOCK cycle is skipped.
